// File: rtl/wb_commit_if.sv
// wb_commit_if: MEM-to-WB instruction handshake and payload bus
interface wb_commit_if;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic [31:0] ms_vaddr;
  logic [5:0]  ms_exc;
  logic        ms_ertn;
  logic        ms_csr_we;
  logic        ms_csr_re;
  logic [13:0] ms_csr_num;
  logic [31:0] ms_csr_wmask;
  logic [31:0] ms_csr_wvalue;
  logic        ms_rf_we;
  logic [4:0]  ms_rf_waddr;
  logic [31:0] ms_rf_wdata;
  modport master (
    output ms_to_ws_valid, ms_pc, ms_vaddr, ms_exc, ms_ertn, ms_csr_we, ms_csr_re,
           ms_csr_num, ms_csr_wmask, ms_csr_wvalue, ms_rf_we, ms_rf_waddr, ms_rf_wdata,
    input  ws_allowin
  );
  modport slave (
    input  ms_to_ws_valid, ms_pc, ms_vaddr, ms_exc, ms_ertn, ms_csr_we, ms_csr_re,
           ms_csr_num, ms_csr_wmask, ms_csr_wvalue, ms_rf_we, ms_rf_waddr, ms_rf_wdata,
    output ws_allowin
  );
endinterface

// File: rtl/wb_commit.sv
// wb_commit: writeback/commit stage with exception priority and CSR/GPR commit; WB_PERF_CNT_EN adds retire/exception counters
module wb_commit #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  wb_commit_if.slave  ms,
  output logic        csr_re,
  output logic [13:0] csr_num,
  input  logic [31:0] csr_rvalue,
  output logic        csr_we,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_vaddr,
  output logic [31:0] wb_pc,
  output logic        ertn_flush,
  output logic        ws_flush,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
`ifdef WB_PERF_CNT_EN
  output logic [31:0] perf_retire,
  output logic [31:0] perf_exc,
`endif
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we
);
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] vaddr;
    logic [5:0]  exc;
    logic        ertn;
    logic        csr_we;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } ws_t;
  logic ws_valid;
  ws_t  ws;
  logic exc_any;
  logic capture;
  assign ms.ws_allowin = 1'b1;
  assign capture = ms.ms_to_ws_valid && ms.ws_allowin && !ws_flush;
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid <= 1'b0;
      ws       <= '0;
    end else begin
      ws_valid <= capture;
      if (capture)
        ws <= {ms.ms_pc, ms.ms_vaddr, ms.ms_exc, ms.ms_ertn, ms.ms_csr_we, ms.ms_csr_re,
               ms.ms_csr_num, ms.ms_csr_wmask, ms.ms_csr_wvalue, ms.ms_rf_we,
               ms.ms_rf_waddr, ms.ms_rf_wdata};
    end
  end
  assign exc_any     = ws_valid && |ws.exc;
  assign wb_ex       = exc_any;
  assign ertn_flush  = ws_valid && ws.ertn && !exc_any;
  assign ws_flush    = wb_ex || ertn_flush;
  assign wb_ecode    = ws.exc[5] ? 6'h00 :
                       ws.exc[4] ? 6'h08 :
                       ws.exc[3] ? 6'h0D :
                       ws.exc[2] ? 6'h0B :
                       ws.exc[1] ? 6'h0C :
                       ws.exc[0] ? 6'h09 : 6'h00;
  assign wb_esubcode = 9'd0;
  assign wb_vaddr    = (ws.exc == 6'b000001) ? ws.vaddr : ws.pc;
  assign wb_pc       = ws.pc;
  assign csr_re      = ws_valid && ws.csr_re && !exc_any;
  assign csr_we      = ws_valid && ws.csr_we && !exc_any;
  assign csr_num     = ws.csr_num;
  assign csr_wmask   = ws.csr_wmask;
  assign csr_wvalue  = ws.csr_wvalue;
  assign rf_we       = ws_valid && ws.rf_we && !exc_any;
  assign rf_waddr    = ws.rf_waddr;
  assign rf_wdata    = ws.csr_re ? csr_rvalue : ws.rf_wdata;
  assign debug_wb_rf_we = {4{rf_we}};
  assign debug_wb_pc    = ws_valid ? ws.pc : RESET_PC;
`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_retire <= '0;
      perf_exc    <= '0;
    end else begin
      if (ws_valid && !exc_any) perf_retire <= perf_retire + 32'd1;
      if (wb_ex) perf_exc <= perf_exc + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_wb_commit.sv
// tb_wb_commit: randomized and directed checks of wb_commit against a behavioural commit model
module tb_wb_commit;
  logic        clk = 1'b0;
  logic        reset;
  logic        csr_re, csr_we, wb_ex, ertn_flush, ws_flush, rf_we;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue, csr_wmask, csr_wvalue, wb_vaddr, wb_pc, rf_wdata, debug_wb_pc;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [4:0]  rf_waddr;
  logic [3:0]  debug_wb_rf_we;
`ifdef WB_PERF_CNT_EN
  logic [31:0] perf_retire, perf_exc;
  logic [31:0] m_retire, m_exc;
`endif
  always #5 clk = ~clk;
  wb_commit_if bus();
  wb_commit dut (
    .clk(clk), .reset(reset), .ms(bus),
    .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue), .csr_we(csr_we),
    .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_vaddr(wb_vaddr),
    .wb_pc(wb_pc), .ertn_flush(ertn_flush), .ws_flush(ws_flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
`ifdef WB_PERF_CNT_EN
    .perf_retire(perf_retire), .perf_exc(perf_exc),
`endif
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we)
  );
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] vaddr;
    logic [5:0]  exc;
    logic        ertn;
    logic        csr_we;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] wmask;
    logic [31:0] wvalue;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } ins_t;
  ins_t offer, held;
  bit   offer_v, held_v, last_flush;
  int   checks = 0, errors = 0;
  logic [5:0] ecode_of [6] = '{6'h09, 6'h0C, 6'h0B, 6'h0D, 6'h08, 6'h00};
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int top_exc(input logic [5:0] e);
    for (int b = 5; b >= 0; b--) if (e[b]) return b;
    return -1;
  endfunction
  task automatic drive(input bit v, input ins_t i);
    offer_v = v;
    offer   = i;
    bus.ms_to_ws_valid = v;
    bus.ms_pc = i.pc;
    bus.ms_vaddr = i.vaddr;
    bus.ms_exc = i.exc;
    bus.ms_ertn = i.ertn;
    bus.ms_csr_we = i.csr_we;
    bus.ms_csr_re = i.csr_re;
    bus.ms_csr_num = i.csr_num;
    bus.ms_csr_wmask = i.wmask;
    bus.ms_csr_wvalue = i.wvalue;
    bus.ms_rf_we = i.rf_we;
    bus.ms_rf_waddr = i.waddr;
    bus.ms_rf_wdata = i.wdata;
  endtask
  task automatic verify();
    bit ex, er, commit;
    int t;
    ex = held_v && held.exc != 0;
    er = held_v && held.ertn && !ex;
    commit = held_v && !ex;
    t = top_exc(held.exc);
    check("ws_allowin", bus.ws_allowin, 1);
    check("wb_ex", wb_ex, ex);
    check("ertn_flush", ertn_flush, er);
    check("ws_flush", ws_flush, ex || er);
    check("csr_re", csr_re, commit && held.csr_re);
    check("csr_we", csr_we, commit && held.csr_we);
    check("rf_we", rf_we, commit && held.rf_we);
    check("debug_rf_we", debug_wb_rf_we, (commit && held.rf_we) ? 4'hF : 4'h0);
    check("csr_num", csr_num, held.csr_num);
    check("csr_wmask", csr_wmask, held.wmask);
    check("csr_wvalue", csr_wvalue, held.wvalue);
    check("wb_pc", wb_pc, held.pc);
    check("rf_waddr", rf_waddr, held.waddr);
    check("rf_wdata", rf_wdata, held.csr_re ? csr_rvalue : held.wdata);
    check("debug_pc", debug_wb_pc, held_v ? held.pc : 32'h1c000000);
    if (ex) begin
      check("wb_ecode", wb_ecode, ecode_of[t]);
      check("wb_esubcode", wb_esubcode, 0);
      check("wb_vaddr", wb_vaddr, (t == 0) ? held.vaddr : held.pc);
    end
`ifdef WB_PERF_CNT_EN
    check("perf_retire", perf_retire, m_retire);
    check("perf_exc", perf_exc, m_exc);
`endif
    last_flush = ex || er;
  endtask
  task automatic step(input bit rst, input bit v, input ins_t i, input logic [31:0] rv);
    reset = rst;
    @(posedge clk);
    #1;
`ifdef WB_PERF_CNT_EN
    if (rst) begin
      m_retire = 0;
      m_exc = 0;
    end else begin
      if (held_v && held.exc == 0) m_retire++;
      if (held_v && held.exc != 0) m_exc++;
    end
`endif
    if (rst) begin
      held_v = 0;
      held = '0;
    end else if (offer_v && !last_flush) begin
      held_v = 1;
      held = offer;
    end else held_v = 0;
    reset = 1'b0;
    drive(v, i);
    csr_rvalue = rv;
    #1;
    verify();
  endtask
  function automatic ins_t rand_ins();
    ins_t r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    r.exc = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
    r.ertn = ($urandom_range(0, 7) == 0);
    r.csr_re = ($urandom_range(0, 3) == 0);
    r.csr_we = ($urandom_range(0, 3) == 0);
    return r;
  endfunction
  initial begin
    ins_t a, z;
    z = '0;
    held = '0;
    held_v = 0;
    last_flush = 0;
    csr_rvalue = 0;
    drive(0, z);
    step(1, 0, z, 32'h55aa55aa);
    check("reset_debug_pc", debug_wb_pc, 32'h1c000000);
    check("reset_rf_wdata", rf_wdata, 0);
    a = z; a.pc = 32'h1c000010; a.rf_we = 1; a.waddr = 5; a.wdata = 32'h1234;
    step(0, 1, a, 0);
    step(0, 0, z, 0);
    check("add_rf_we", rf_we, 1);
    check("add_rf_wdata", rf_wdata, 32'h1234);
    check("add_flush", ws_flush, 0);
    a = z; a.pc = 32'h1c000014; a.csr_re = 1; a.csr_num = 14'h30; a.rf_we = 1; a.waddr = 7;
    step(0, 1, a, 0);
    step(0, 0, z, 32'hdeadbeef);
    check("csrrd_re", csr_re, 1);
    check("csrrd_num", csr_num, 14'h30);
    check("csrrd_wdata", rf_wdata, 32'hdeadbeef);
    a = z; a.pc = 32'h1c000020; a.vaddr = 3; a.exc = 6'b000101; a.rf_we = 1;
    step(0, 1, a, 0);
    step(0, 0, z, 0);
    check("sysale_ecode", wb_ecode, 6'h0B);
    check("sysale_pc", wb_pc, 32'h1c000020);
    check("sysale_flush", ws_flush, 1);
    step(0, 0, z, 0);
    check("sysale_flush_gone", ws_flush, 0);
    a = z; a.pc = 32'h1c000024; a.vaddr = 32'h80000002; a.exc = 6'b000001;
    step(0, 1, a, 0);
    step(0, 0, z, 0);
    check("ale_ecode", wb_ecode, 6'h09);
    check("ale_vaddr", wb_vaddr, 32'h80000002);
    a = z; a.pc = 32'h1c000001; a.vaddr = 32'h12345678; a.exc = 6'b010000;
    step(0, 1, a, 0);
    step(0, 0, z, 0);
    check("adef_ecode", wb_ecode, 6'h08);
    check("adef_vaddr", wb_vaddr, 32'h1c000001);
    a = z; a.pc = 32'h1c000030; a.ertn = 1;
    step(0, 1, a, 0);
    a = z; a.pc = 32'h1c000034; a.rf_we = 1; a.waddr = 9; a.wdata = 32'h77;
    step(0, 1, a, 0);
    check("ertn_flush", ertn_flush, 1);
    step(0, 0, z, 0);
    check("ertn_drop_pc", debug_wb_pc, 32'h1c000000);
    check("ertn_drop_rf_we", rf_we, 0);
    a = z; a.pc = 32'h1c000040; a.ertn = 1; a.exc = 6'b000100;
    step(0, 1, a, 0);
    step(0, 0, z, 0);
    check("ertn_exc_ertn", ertn_flush, 0);
    check("ertn_exc_ex", wb_ex, 1);
    a = z; a.pc = 32'h1c000050; a.csr_we = 1; a.csr_num = 14'h5; a.wmask = 32'hffffffff; a.wvalue = 32'h1;
    step(0, 1, a, 0);
    step(0, 0, z, 0);
    check("csrwr_we", csr_we, 1);
    step(1, 0, z, 0);
    check("rst_csr_we", csr_we, 0);
    check("rst_debug_pc", debug_wb_pc, 32'h1c000000);
    step(0, 0, z, 0);
    check("post_rst_csr_we", csr_we, 0);
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, rand_ins(), $urandom);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_commit.md
Name: wb_commit

Overview:
Writeback/commit stage of the 5-stage LoongArch32 pipeline, and the initiating side of the CSR file's command and exception interface. It latches one instruction from MEM through a valid/allowin handshake and resolves exception priority. It then drives the CSR read/write command, the exception trap (wb_ex/ecode/esubcode/vaddr/pc), ertn_flush and the register-file write, and broadcasts a one-cycle pipeline flush.

Parameters:
- RESET_PC, 32'h1c000000, pc value shown on the debug port while the stage is empty.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ms_to_ws_valid  in  1  MEM offers an instruction
ws_allowin  out  1  WB accepts this cycle
ms_pc  in  32  instruction pc
ms_vaddr  in  32  load/store virtual address
ms_exc  in  6  exception flags {int,adef,ine,sys,brk,ale}, bit5 = int
ms_ertn  in  1  instruction is ertn
ms_csr_we  in  1  csr write (csrwr/csrxchg)
ms_csr_re  in  1  csr read
ms_csr_num  in  14  csr number
ms_csr_wmask  in  32  csr write mask
ms_csr_wvalue  in  32  csr write value
ms_rf_we  in  1  gpr write enable
ms_rf_waddr  in  5  gpr index
ms_rf_wdata  in  32  gpr data (non-csr result)
csr_re  out  1  csr read strobe
csr_num  out  14  csr number
csr_rvalue  in  32  csr read data (combinational)
csr_we  out  1  csr write strobe
csr_wmask  out  32  csr write mask
csr_wvalue  out  32  csr write value
wb_ex  out  1  exception commit
wb_ecode  out  6  exception code
wb_esubcode  out  9  exception subcode
wb_vaddr  out  32  faulting data address
wb_pc  out  32  pc of committing instruction
ertn_flush  out  1  ertn commit
ws_flush  out  1  flush pulse to IF/ID/EX/MEM
rf_we  out  1  gpr write
rf_waddr  out  5  gpr index
rf_wdata  out  32  gpr data
debug_wb_pc  out  32  trace pc
debug_wb_rf_we  out  4  trace byte enables

Behaviour:
- Stage register: ws_valid plus all ms_* fields; one instruction deep, ready_go is always 1, ws_allowin = 1 (constant).
- Capture on posedge when ms_to_ws_valid && ws_allowin && !ws_flush. A flush cycle clears ws_valid and drops any offered instruction, because upstream is flushed on the same cycle.
- Latency: instruction captured at edge N commits combinationally during cycle N+1.
- exc_any = ws_valid && |ws_exc.
- Priority and codes:
  - int: ecode 0x00, sub 0
  - adef: ecode 0x08, sub 0
  - ine: ecode 0x0D
  - sys: ecode 0x0B
  - brk: ecode 0x0C
  - ale: ecode 0x09, sub 0
  - only the highest set flag is reported; esubcode is 0 for all listed codes.
- wb_ex = exc_any. ertn_flush = ws_valid && ws_ertn && !exc_any. ws_flush = wb_ex || ertn_flush.
- wb_pc = ws_pc always. wb_vaddr = ws_vaddr when ale wins, else ws_pc (adef reports pc).
- csr_re = ws_valid && ws_csr_re && !exc_any; csr_we is gated the same way. csr_num/wmask/wvalue are passed through from the stage register.
- rf_we = ws_valid && ws_rf_we && !exc_any. rf_wdata = ws_csr_re ? csr_rvalue : ws_rf_wdata.
- debug_wb_rf_we = {4{rf_we}}. debug_wb_pc = ws_valid ? ws_pc : RESET_PC.
- Reset: ws_valid=0, so every strobe (wb_ex, ertn_flush, ws_flush, csr_we, csr_re, rf_we) reads 0. Data outputs reset to 0; debug_wb_pc = RESET_PC. Reset mid-instruction discards it with no CSR/GPR side effect.
- ertn combined with any exception flag: the exception wins and ertn_flush=0.

Optional Feature:
WB_PERF_CNT_EN: adds outputs perf_retire[31:0] and perf_exc[31:0], both reset to 0 and wrapping 0xFFFFFFFF->0. perf_retire increments on every cycle with ws_valid && !exc_any; perf_exc increments on wb_ex. Without the macro, these ports and counters do not exist.

Test Plan:
- ADD at pc 0x1c000010, rf_waddr 5, data 0x1234 -> one cycle later rf_we=1, rf_waddr=5, rf_wdata=0x1234, ws_flush=0.
- csrrd num 0x30 with csr_rvalue=0xdeadbeef -> csr_re=1, csr_num=0x30, rf_wdata=0xdeadbeef.
- ms_exc=6'b000101 (sys+ale), pc 0x1c000020, vaddr 0x3 -> wb_ex=1, ecode=0x0B, wb_pc=0x1c000020, rf_we=0, ws_flush=1 for one cycle.
- ale only, vaddr 0x80000002 -> ecode=0x09, wb_vaddr=0x80000002; adef only, pc 0x1c000001 -> ecode=0x08, wb_vaddr=0x1c000001.
- ertn followed by ms_to_ws_valid=1 during the flush cycle -> ertn_flush=1, next cycle ws_valid=0 (offered instruction dropped).
- Reset asserted while a csrwr is held in WB -> csr_we=0 on and after the reset edge, all strobes 0, debug_wb_pc=0x1c000000.
